// File: rtl/tow_match_scorer_pkg.sv
// tow_pkg: shared game-state encoding, move-direction helper and error display pattern
package tow_pkg;
  typedef enum logic [1:0] {PLAY = 2'd0, HOLD = 2'd1, MATCH_OVER = 2'd2} state_t;
  localparam logic [14:0] ERR_PAT = 15'h5555;
  function automatic logic mr_f(input logic right, input logic leds_on);
    return right ~^ leds_on;
  endfunction
endpackage

// File: rtl/tow_score_decode.sv
// tow_score_decode: maps game state, rope position and last winner to the LED cell pattern
module tow_score_decode
  import tow_pkg::*;
#(
  parameter int HALF = 3,
  parameter int PW   = 3
) (
  input  state_t                i_state,
  input  logic signed [PW-1:0]  i_pos,
  input  logic                  i_winner_right,
  output logic [2*HALF:0]       o_score
);
  localparam logic [2*HALF:0] R_PAT = (2*HALF+1)'((1 << HALF) - 1);
  localparam logic [2*HALF:0] L_PAT = R_PAT << (HALF + 1);
  logic [2*HALF:0] w_one_hot;
  assign w_one_hot = (2*HALF+1)'(1) << (HALF - int'(i_pos));
  assign o_score = (i_state == PLAY) ? w_one_hot :
                   (i_state == HOLD || i_state == MATCH_OVER) ? (i_winner_right ? R_PAT : L_PAT) :
                   ERR_PAT[2*HALF:0];
endmodule

// File: rtl/tow_match_scorer.sv
// tow_match_scorer: best-of-N tug-of-war scorer with favour-the-loser and jump-the-light rules
module tow_match_scorer
  import tow_pkg::*;
#(
  parameter int HALF       = 3,
  parameter int MATCH_WINS = 2,
  parameter int HOLD_CYC   = 8,
  parameter int FTL_EN     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            winrnd,
  input  logic            right,
  input  logic            leds_on,
  input  logic            new_match,
  output logic [2*HALF:0] score,
  output logic            game_over,
  output logic            match_over,
  output logic            winner_right,
  output logic [3:0]      games_l,
  output logic [3:0]      games_r
);
  localparam int PW = $clog2(HALF + 1) + 1;
  localparam int CW = $clog2(HOLD_CYC + 1);
  state_t               r_state;
  logic signed [PW-1:0] r_pos;
  logic [CW-1:0]        r_cnt;
  logic                 r_winner_right;
  logic [3:0]           r_games_l, r_games_r;
  logic                 w_mr, w_dbl;
  int                   w_step, w_sum, w_next;
  always_comb begin
    w_mr   = mr_f(right, leds_on);
    w_step = w_mr ? 1 : -1;
    w_dbl  = (FTL_EN != 0) && leds_on &&
             ((int'(r_pos) == HALF && !w_mr) || (int'(r_pos) == -HALF && w_mr));
    w_sum  = int'(r_pos) + (w_dbl ? 2 * w_step : w_step);
    // a doubled step toward centre stops at N rather than crossing it
    w_next = (w_dbl && (w_sum * int'(r_pos) < 0)) ? 0 : w_sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= PLAY;
      r_pos          <= '0;
      r_cnt          <= '0;
      r_winner_right <= 1'b0;
      r_games_l      <= '0;
      r_games_r      <= '0;
    end else if (new_match) begin
      r_state   <= PLAY;
      r_pos     <= '0;
      r_cnt     <= '0;
      r_games_l <= '0;
      r_games_r <= '0;
    end else begin
      case (r_state)
        PLAY: if (winrnd) begin
          if (w_next > HALF || w_next < -HALF) begin
            r_state        <= HOLD;
            r_cnt          <= CW'(HOLD_CYC);
            r_winner_right <= w_next > HALF;
            if (w_next > HALF)
              r_games_r <= (r_games_r == 4'(MATCH_WINS)) ? r_games_r : r_games_r + 4'd1;
            else
              r_games_l <= (r_games_l == 4'(MATCH_WINS)) ? r_games_l : r_games_l + 4'd1;
          end else begin
            r_pos <= PW'(w_next);
          end
        end
        HOLD: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if ((r_winner_right ? r_games_r : r_games_l) == 4'(MATCH_WINS)) begin
              r_state <= MATCH_OVER;
            end else begin
              r_state <= PLAY;
              r_pos   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
  tow_score_decode #(.HALF(HALF), .PW(PW)) u_decode (
    .i_state       (r_state),
    .i_pos         (r_pos),
    .i_winner_right(r_winner_right),
    .o_score       (score)
  );
  assign game_over    = (r_state == HOLD) || (r_state == MATCH_OVER);
  assign match_over   = (r_state == MATCH_OVER);
  assign winner_right = r_winner_right;
  assign games_l      = r_games_l;
  assign games_r      = r_games_r;
endmodule

// File: tb/tb_tow_match_scorer.sv
// tb_tow_match_scorer: directed and random checks of two scorers (favour-the-loser on/off) against a rules model
module tb_tow_match_scorer;
  localparam int HALF = 3, MW = 2, HC = 4, W = 2*HALF+1;
  logic clk = 0, rst_n = 0, winrnd = 0, right = 0, leds_on = 0, new_match = 0;
  logic [W-1:0] score [2];
  logic         game_over [2], match_over [2], winner_right [2];
  logic [3:0]   games_l [2], games_r [2];
  int checks = 0, failures = 0;
  int m_pos [2], m_st [2], m_cnt [2], m_gl [2], m_gr [2];
  logic m_wr [2];

  tow_match_scorer #(.HALF(HALF), .MATCH_WINS(MW), .HOLD_CYC(HC), .FTL_EN(1)) u_ftl (
    .clk(clk), .rst_n(rst_n), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .new_match(new_match), .score(score[0]), .game_over(game_over[0]),
    .match_over(match_over[0]), .winner_right(winner_right[0]),
    .games_l(games_l[0]), .games_r(games_r[0]));
  tow_match_scorer #(.HALF(HALF), .MATCH_WINS(MW), .HOLD_CYC(HC), .FTL_EN(0)) u_noftl (
    .clk(clk), .rst_n(rst_n), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .new_match(new_match), .score(score[1]), .game_over(game_over[1]),
    .match_over(match_over[1]), .winner_right(winner_right[1]),
    .games_l(games_l[1]), .games_r(games_r[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_gl[k] = 0; m_gr[k] = 0; m_wr[k] = 0;
    end
  endtask

  // st: 0 = playing, 1 = showing a game win, 2 = match decided
  task automatic model_step(input logic w, input logic r, input logic l, input logic nm);
    int dir, mag, np;
    for (int k = 0; k < 2; k++) begin
      if (nm) begin
        m_st[k] = 0; m_pos[k] = 0; m_gl[k] = 0; m_gr[k] = 0; m_cnt[k] = 0;
      end else if (m_st[k] == 0 && w) begin
        dir = (r == l) ? 1 : -1;
        mag = (k == 0 && l && (m_pos[k] == HALF || m_pos[k] == -HALF) && dir * m_pos[k] < 0) ? 2 : 1;
        np = m_pos[k] + dir * mag;
        if (mag == 2 && np * m_pos[k] < 0) np = 0;
        if (np > HALF || np < -HALF) begin
          m_st[k] = 1; m_cnt[k] = HC; m_wr[k] = (np > HALF);
          if (np > HALF) m_gr[k] = (m_gr[k] < MW) ? m_gr[k] + 1 : m_gr[k];
          else m_gl[k] = (m_gl[k] < MW) ? m_gl[k] + 1 : m_gl[k];
        end else m_pos[k] = np;
      end else if (m_st[k] == 1) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          if ((m_wr[k] ? m_gr[k] : m_gl[k]) >= MW) m_st[k] = 2;
          else begin m_st[k] = 0; m_pos[k] = 0; end
        end
      end
    end
  endtask

  function automatic logic [W-1:0] exp_score(int k);
    if (m_st[k] == 0) return W'(1) << (HALF - m_pos[k]);
    return m_wr[k] ? 7'b0000111 : 7'b1110000;
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/dut%0d/score", tag, k), 32'(score[k]), 32'(exp_score(k)));
      chk($sformatf("%s/dut%0d/game_over", tag, k), 32'(game_over[k]), 32'(m_st[k] != 0));
      chk($sformatf("%s/dut%0d/match_over", tag, k), 32'(match_over[k]), 32'(m_st[k] == 2));
      chk($sformatf("%s/dut%0d/winner_right", tag, k), 32'(winner_right[k]), 32'(m_wr[k]));
      chk($sformatf("%s/dut%0d/games_l", tag, k), 32'(games_l[k]), 32'(m_gl[k]));
      chk($sformatf("%s/dut%0d/games_r", tag, k), 32'(games_r[k]), 32'(m_gr[k]));
    end
  endtask

  task automatic step(input logic w, input logic r, input logic l, input logic nm);
    winrnd = w; right = r; leds_on = l; new_match = nm;
    @(posedge clk);
    model_step(w, r, l, nm);
    #1;
    winrnd = 0; new_match = 0;
    check_all("model");
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_score", 32'(score[0]), 32'(7'b0001000));
    chk("reset_games", {games_l[0], games_r[0]}, 32'h0);
    check_all("reset");
    rst_n = 1;
    // proper right pushes walk to R3, then right wins
    step(1, 1, 1, 0); chk("r1", 32'(score[0]), 32'(7'b0000100));
    step(1, 1, 1, 0); chk("r2", 32'(score[0]), 32'(7'b0000010));
    step(1, 1, 1, 0); chk("r3", 32'(score[0]), 32'(7'b0000001));
    step(1, 1, 1, 0); chk("rwin_score", 32'(score[0]), 32'(7'b0000111));
    chk("rwin_over", 32'(game_over[0]), 32'd1);
    chk("rwin_games", 32'(games_r[0]), 32'd1);
    step(1, 0, 1, 0); chk("hold_ignore", 32'(score[0]), 32'(7'b0000111));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); chk("hold_3", 32'(game_over[0]), 32'd1);
    step(0, 0, 0, 0); chk("hold_end_score", 32'(score[0]), 32'(7'b0001000));
    chk("hold_end_over", 32'(game_over[0]), 32'd0);
    // favour-the-loser from L3
    repeat (3) step(1, 0, 1, 0);
    chk("l3", 32'(score[0]), 32'(7'b1000000));
    step(1, 1, 1, 0);
    chk("ftl_on", 32'(score[0]), 32'(7'b0010000));
    chk("ftl_off", 32'(score[1]), 32'(7'b0100000));
    step(0, 0, 0, 1); chk("nm_score", 32'(score[1]), 32'(7'b0001000));
    // jump-the-light both ways
    repeat (3) step(1, 1, 1, 0);
    step(1, 0, 0, 0); chk("jtl_right", 32'(score[0]), 32'(7'b0000111));
    repeat (HC) step(0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0);
    step(1, 1, 0, 0); chk("jtl_left", 32'(score[0]), 32'(7'b1110000));
    chk("jtl_left_games", 32'(games_l[0]), 32'd1);
    repeat (HC) step(0, 0, 0, 0);
    // second right win takes the match
    repeat (4) step(1, 1, 1, 0);
    repeat (HC) step(0, 0, 0, 0);
    chk("match_over", 32'(match_over[0]), 32'd1);
    chk("match_games_r", 32'(games_r[0]), 32'd2);
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      chk("match_held", 32'(score[0]), 32'(7'b0000111));
    end
    step(0, 0, 0, 1);
    chk("nm_after_match", {score[0], games_l[0], games_r[0]}, {7'b0001000, 8'h00});
    // new_match beats a simultaneous push
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    chk("nm_priority", 32'(score[0]), 32'(7'b0001000));
    // async reset in the middle of a win display
    repeat (4) step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_hold_score", 32'(score[0]), 32'(7'b0001000));
    chk("rst_hold_over", 32'(game_over[0]), 32'd0);
    check_all("rst_hold");
    #2 rst_n = 1;
    @(posedge clk); #1;
    check_all("rst_release");
    // random play
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
